// File: rtl/schmidl_cox_pkg.sv
// Shared types and helpers for the Schmidl-Cox preamble correlator.
//   sc16_t        : complex 16-bit sample, I in [31:16], Q in [15:0]
//   cplx_t        : complex lag product, 33-bit signed re/im (66 bits)
//   ACC_W_DEFAULT : default signed accumulator width
//   sat16()       : clamp a signed value to the 16-bit range
package schmidl_cox_pkg;

    localparam int ACC_W_DEFAULT = 48;

    typedef struct packed {
        logic signed [15:0] i;
        logic signed [15:0] q;
    } sc16_t;

    typedef struct packed {
        logic signed [32:0] re;
        logic signed [32:0] im;
    } cplx_t;

    // Argument is 64 bits wide so any accumulator width up to 63 bits can be
    // sign-extended into it by the caller.
    function automatic logic signed [15:0] sat16(input logic signed [63:0] v);
        if (v > 64'sd32767) begin
            return 16'sh7fff;
        end else if (v < -64'sd32768) begin
            return 16'sh8000;
        end else begin
            return v[15:0];
        end
    endfunction

endpackage

// File: rtl/schmidl_cox_delay_line.sv
// Stall-enabled DEPTH-sample delay line with a fill counter.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset (pointer and fill counter only)
//   en_i   : advance by one item (write din_i, read the item DEPTH writes ago)
//   din_i  : data written on this advance
//   dout_o : item written DEPTH advances earlier, or zero while fewer than
//            DEPTH items have been written since reset
// DEPTH must be a power of two so the pointer wraps by itself.
module schmidl_cox_delay_line #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 512
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_q;
    logic [AW-1:0]    ptr_q;
    logic [AW:0]      fill_q;
    logic             hit_q;

    // NOTE: the RAM and its read register have no reset so the array maps
    // onto block RAM; stale contents after reset are masked by hit_q instead.
    // NOTE: sequential state uses non-blocking assignments so the read of
    // mem[ptr_q] sees the old word (read-before-write) regardless of order.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            rd_q         <= mem[ptr_q];
            mem[ptr_q]   <= din_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q  <= '0;
            fill_q <= '0;
            hit_q  <= 1'b0;
        end else if (en_i) begin
            ptr_q <= ptr_q + 1'b1;
            // The word read now was written DEPTH advances ago only once the
            // line has been filled completely.
            hit_q <= (fill_q == (AW + 1)'(DEPTH));
            if (fill_q != (AW + 1)'(DEPTH)) begin
                fill_q <= fill_q + 1'b1;
            end
        end
    end

    assign dout_o = hit_q ? rd_q : '0;

endmodule

// File: rtl/schmidl_cox.sv
// Schmidl-Cox timing metric: sliding-window lag-L autocorrelation P and
// window energy R, one output item per accepted input item.
//   ce_clk, ce_rst_n             : clock, asynchronous active-low reset
//   s_axis_tdata/tvalid/tlast/tready : sc16 sample stream in
//   m_axis_tdata/tvalid/tlast/tready : {sat16(|P|>>>SHIFT), sat16(R>>>SHIFT)}
// Pipeline (each register advances only when en is high):
//   S1 sample + x(n-L)   S2 lag product, energies, a(n-L)
//   S3 running sums      S4 |Pre|, |Pim|      S5 magnitude, saturate, output
// L must be a power of two, at least 4; ACC_W must not exceed 63.
module schmidl_cox
    import schmidl_cox_pkg::*;
#(
    parameter int L     = 512,
    parameter int SHIFT = 25,
    parameter int ACC_W = ACC_W_DEFAULT
) (
    input  logic        ce_clk,
    input  logic        ce_rst_n,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready
);

    function automatic logic signed [31:0] sx32(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic signed [ACC_W-1:0] sx_acc(input logic [32:0] v);
        return {{(ACC_W - 33){v[32]}}, v};
    endfunction

    function automatic logic signed [ACC_W-1:0] zx_acc(input logic [32:0] v);
        return {{(ACC_W - 33){1'b0}}, v};
    endfunction

    logic en;
    logic acc_in;
    logic rdy_q;

    logic  v1_q, v2_q, v3_q, v4_q;
    logic  l1_q, l2_q, l3_q, l4_q;
    sc16_t x1_q;
    sc16_t y_w;
    cplx_t prod_d;
    cplx_t a2_q;
    cplx_t a_old_w;
    logic [32:0] e_d, ey_d;
    logic [32:0] e2_q, ey2_q;

    logic signed [ACC_W-1:0] p_re_q, p_im_q, r_q;
    logic signed [ACC_W-1:0] pabs_re_q, pabs_im_q, r4_q;

    logic signed [31:0] p_ii, p_qq, p_iq, p_qi;
    logic signed [31:0] ex_ii, ex_qq, ey_ii, ey_qq;
    logic signed [ACC_W-1:0] mx_d, mn_d;
    logic signed [ACC_W:0]   mag_d;
    logic signed [15:0]      corr16_d, r16_d;

    logic        m_valid_q, m_last_q;
    logic [31:0] m_data_q;

    // Whole pipeline moves in lock-step whenever the output register is free.
    assign en            = !m_valid_q || m_axis_tready;
    assign s_axis_tready = en && rdy_q;
    assign acc_in        = s_axis_tvalid && s_axis_tready;

    // Holds tready low until the first edge after reset release.
    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
        end
    end

    // x(n-L): advances once per accepted sample, so bubbles do not count.
    schmidl_cox_delay_line #(
        .WIDTH (32),
        .DEPTH (L)
    ) u_dl_x (
        .clk_i  (ce_clk),
        .rst_ni (ce_rst_n),
        .en_i   (acc_in),
        .din_i  (s_axis_tdata),
        .dout_o (y_w)
    );

    // a(n-L): fed from the S2 combinational product so its output lands in
    // the same cycle as a2_q.
    schmidl_cox_delay_line #(
        .WIDTH (66),
        .DEPTH (L)
    ) u_dl_a (
        .clk_i  (ce_clk),
        .rst_ni (ce_rst_n),
        .en_i   (en && v1_q),
        .din_i  (prod_d),
        .dout_o (a_old_w)
    );

    // S2 arithmetic: a = conj(y) * x, e = |x|^2, ey = |y|^2.
    // NOTE: every always_comb output gets a default first so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        prod_d = '0;
        p_ii   = sx32(y_w.i) * sx32(x1_q.i);
        p_qq   = sx32(y_w.q) * sx32(x1_q.q);
        p_iq   = sx32(y_w.i) * sx32(x1_q.q);
        p_qi   = sx32(y_w.q) * sx32(x1_q.i);
        ex_ii  = sx32(x1_q.i) * sx32(x1_q.i);
        ex_qq  = sx32(x1_q.q) * sx32(x1_q.q);
        ey_ii  = sx32(y_w.i) * sx32(y_w.i);
        ey_qq  = sx32(y_w.q) * sx32(y_w.q);
        prod_d.re = {p_ii[31], p_ii} + {p_qq[31], p_qq};
        prod_d.im = {p_iq[31], p_iq} - {p_qi[31], p_qi};
        // Squares are non-negative and at most 2^30, so zero-extension is exact.
        e_d  = {1'b0, ex_ii} + {1'b0, ex_qq};
        ey_d = {1'b0, ey_ii} + {1'b0, ey_qq};
    end

    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) begin
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            v3_q      <= 1'b0;
            v4_q      <= 1'b0;
            l1_q      <= 1'b0;
            l2_q      <= 1'b0;
            l3_q      <= 1'b0;
            l4_q      <= 1'b0;
            x1_q      <= '0;
            a2_q      <= '0;
            e2_q      <= '0;
            ey2_q     <= '0;
            p_re_q    <= '0;
            p_im_q    <= '0;
            r_q       <= '0;
            pabs_re_q <= '0;
            pabs_im_q <= '0;
            r4_q      <= '0;
        end else if (en) begin
            // S1
            v1_q <= acc_in;
            l1_q <= s_axis_tlast;
            x1_q <= s_axis_tdata;
            // S2
            v2_q  <= v1_q;
            l2_q  <= l1_q;
            a2_q  <= prod_d;
            e2_q  <= e_d;
            ey2_q <= ey_d;
            // S3: only real items move the running sums.
            v3_q <= v2_q;
            l3_q <= l2_q;
            if (v2_q) begin
                p_re_q <= p_re_q + sx_acc(a2_q.re) - sx_acc(a_old_w.re);
                p_im_q <= p_im_q + sx_acc(a2_q.im) - sx_acc(a_old_w.im);
                r_q    <= r_q + zx_acc(e2_q) - zx_acc(ey2_q);
            end
            // S4
            v4_q      <= v3_q;
            l4_q      <= l3_q;
            pabs_re_q <= p_re_q[ACC_W-1] ? -p_re_q : p_re_q;
            pabs_im_q <= p_im_q[ACC_W-1] ? -p_im_q : p_im_q;
            r4_q      <= r_q;
        end
    end

    // S5: max + min/2 magnitude estimate, then scale and clamp both fields.
    always_comb begin
        mx_d = pabs_im_q;
        mn_d = pabs_re_q;
        if (pabs_re_q >= pabs_im_q) begin
            mx_d = pabs_re_q;
            mn_d = pabs_im_q;
        end
        mag_d    = {1'b0, mx_d} + {mn_d[ACC_W-1], mn_d >>> 1};
        corr16_d = sat16(64'(mag_d >>> SHIFT));
        r16_d    = sat16(64'(r4_q >>> SHIFT));
    end

    // Output register holds while stalled, keeping tdata/tlast stable.
    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
        end else if (en) begin
            m_valid_q <= v4_q;
            m_last_q  <= v4_q && l4_q;
            m_data_q  <= {corr16_d, r16_d};
        end
    end

    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tlast  = m_last_q;
    assign m_axis_tdata  = m_data_q;

endmodule

// File: tb/tb_schmidl_cox.sv
// Directed bench for schmidl_cox: a small-lag instance (L=16, SHIFT=20) and
// a full-size instance (L=512, SHIFT=25) sharing one stimulus port, chosen
// by sel. Expected values are hand-derived constants, plus a direct
// window-sum model for the random-data packets.
module tb_schmidl_cox;

    localparam int L_T       = 16;
    localparam int SHIFT_T   = 20;
    localparam int CYC_LIMIT = 5000;
    localparam int NMAX      = 1100;

    logic        clk;
    logic        rst_n;
    logic        sel;
    logic [31:0] s_data;
    logic        s_valid, s_last, m_ready;

    logic        s_ready, m_valid, m_last;
    logic [31:0] m_data;

    logic        sra, mva, mla, srb, mvb, mlb;
    logic [31:0] mda, mdb;

    logic [31:0] in_data [NMAX];
    bit          in_last [NMAX];
    logic [31:0] out_d [$];
    bit          out_l [$];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    schmidl_cox #(
        .L     (L_T),
        .SHIFT (SHIFT_T),
        .ACC_W (48)
    ) dut (
        .ce_clk        (clk),
        .ce_rst_n      (rst_n),
        .s_axis_tdata  (s_data),
        .s_axis_tvalid (s_valid && !sel),
        .s_axis_tlast  (s_last),
        .s_axis_tready (sra),
        .m_axis_tdata  (mda),
        .m_axis_tvalid (mva),
        .m_axis_tlast  (mla),
        .m_axis_tready (m_ready)
    );

    schmidl_cox #(
        .L     (512),
        .SHIFT (25),
        .ACC_W (48)
    ) dut_fs (
        .ce_clk        (clk),
        .ce_rst_n      (rst_n),
        .s_axis_tdata  (s_data),
        .s_axis_tvalid (s_valid && sel),
        .s_axis_tlast  (s_last),
        .s_axis_tready (srb),
        .m_axis_tdata  (mdb),
        .m_axis_tvalid (mvb),
        .m_axis_tlast  (mlb),
        .m_axis_tready (m_ready)
    );

    assign s_ready = sel ? srb : sra;
    assign m_valid = sel ? mvb : mva;
    assign m_last  = sel ? mlb : mla;
    assign m_data  = sel ? mdb : mda;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] bsat(input longint v);
        if (v > 32767) return 16'h7fff;
        if (v < -32768) return 16'h8000;
        return v[15:0];
    endfunction

    // Direct sum over the L_T-sample window ending at item n.
    function automatic logic [31:0] model(input int n);
        longint pr, pim, r, xi, xq, yi, yq, ar, ai, mx, mn, m;
        pr = 0; pim = 0; r = 0;
        for (int k = n - L_T + 1; k <= n; k++) begin
            if (k < 0) continue;
            xi = longint'($signed(in_data[k][31:16]));
            xq = longint'($signed(in_data[k][15:0]));
            r += xi * xi + xq * xq;
            if (k >= L_T) begin
                yi = longint'($signed(in_data[k-L_T][31:16]));
                yq = longint'($signed(in_data[k-L_T][15:0]));
                pr  += yi * xi + yq * xq;
                pim += yi * xq - yq * xi;
            end
        end
        ar = (pr < 0) ? -pr : pr;
        ai = (pim < 0) ? -pim : pim;
        mx = (ar >= ai) ? ar : ai;
        mn = (ar >= ai) ? ai : ar;
        m  = mx + (mn >>> 1);
        return {bsat(m >>> SHIFT_T), bsat(r >>> SHIFT_T)};
    endfunction

    // Constant {16384,0} input at L=16, SHIFT=20: each sample adds 2^28.
    function automatic logic [31:0] exp_const(input int i);
        int rf, cf;
        rf = ((i + 1 < L_T) ? i + 1 : L_T) * 256;
        cf = (i < L_T) ? 0 : (((i - L_T + 1) < L_T) ? (i - L_T + 1) : L_T) * 256;
        return {cf[15:0], rf[15:0]};
    endfunction

    task automatic clear_last();
        for (int i = 0; i < NMAX; i++) in_last[i] = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Streams in_data[0..n-1] with stall% random gaps on both sides and
    // collects every output handshake into out_d/out_l.
    task automatic run(input int n, input int stall, input bit wait_out);
        int ni, no, cyc;
        ni = 0; no = 0; cyc = 0;
        out_d.delete();
        out_l.delete();
        while ((ni < n || (wait_out && no < n)) && cyc < CYC_LIMIT) begin
            @(negedge clk);
            s_valid = (ni < n) && ($urandom_range(99) >= stall);
            s_data  = in_data[(ni < n) ? ni : 0];
            s_last  = in_last[(ni < n) ? ni : 0];
            m_ready = ($urandom_range(99) >= stall);
            #1;
            if (s_valid && s_ready) ni++;
            if (m_valid && m_ready) begin
                out_d.push_back(m_data);
                out_l.push_back(m_last);
                no++;
            end
            cyc++;
        end
        @(negedge clk);
        s_valid = 1'b0;
        m_ready = 1'b0;
        check("cycle_budget", 64'(cyc < CYC_LIMIT), 64'd1);
    endtask

    initial begin
        rst_n   = 1'b0;
        sel     = 1'b0;
        s_data  = '0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        clear_last();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_s_ready", 64'(s_ready), 64'd0);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_last",  64'(m_last),  64'd0);
        check("rst_m_data",  64'(m_data),  64'd0);
        rst_n = 1'b1;
        #1 check("ready_before_edge", 64'(s_ready), 64'd0);
        @(negedge clk);
        #1 check("ready_after_edge", 64'(s_ready), 64'd1);

        // Single item: 4-cycle latency, then hold under backpressure
        @(negedge clk);
        s_data  = 32'h4000_0000;
        s_last  = 1'b1;
        s_valid = 1'b1;
        #1 check("single_accept", 64'(s_ready), 64'd1);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1 check($sformatf("latency_low[%0d]", k), 64'(m_valid), 64'd0);
            @(negedge clk);
        end
        #1;
        check("latency_valid", 64'(m_valid), 64'd1);
        check("single_data",   64'(m_data),  64'h0000_0100);
        check("single_last",   64'(m_last),  64'd1);
        @(negedge clk);
        #1;
        check("hold_valid",    64'(m_valid), 64'd1);
        check("hold_data",     64'(m_data),  64'h0000_0100);
        check("hold_last",     64'(m_last),  64'd1);
        check("hold_s_ready",  64'(s_ready), 64'd0);
        m_ready = 1'b1;
        @(negedge clk);
        #1 check("drained", 64'(m_valid), 64'd0);
        m_ready = 1'b0;

        // Constant input ramp
        do_reset();
        clear_last();
        for (int i = 0; i < 40; i++) in_data[i] = 32'h4000_0000;
        in_last[39] = 1'b1;
        run(40, 0, 1'b1);
        check("const_count", 64'(out_d.size()), 64'd40);
        for (int i = 0; i < 40; i++) check($sformatf("const[%0d]", i), 64'(out_d[i]), 64'(exp_const(i)));
        check("const_last39", 64'(out_l[39]), 64'd1);
        check("const_last38", 64'(out_l[38]), 64'd0);

        // Sign flip after L samples: |P| ignores the sign of the correlation,
        // so the anti-correlated half ramps the field just like the constant case.
        do_reset();
        clear_last();
        for (int i = 0; i < 2 * L_T; i++) in_data[i] = (i < L_T) ? 32'h4000_0000 : 32'hc000_0000;
        run(2 * L_T, 0, 1'b1);
        check("alt_item15", 64'(out_d[L_T-1]),       64'h0000_1000);
        check("alt_item23", 64'(out_d[L_T+L_T/2-1]), 64'h0800_1000);
        check("alt_item31", 64'(out_d[2*L_T-1]),     64'h1000_1000);

        // Two 64-item packets of random samples, no stall then 25% stall
        clear_last();
        for (int i = 0; i < 128; i++) in_data[i] = $urandom;
        in_last[63]  = 1'b1;
        in_last[127] = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            run(128, (pass == 0) ? 0 : 25, 1'b1);
            check($sformatf("pkt%0d_count", pass), 64'(out_d.size()), 64'd128);
            for (int i = 0; i < 128; i++) begin
                check($sformatf("pkt%0d_data[%0d]", pass, i), 64'(out_d[i]), 64'(model(i)));
                check($sformatf("pkt%0d_last[%0d]", pass, i), 64'(out_l[i]), 64'(in_last[i]));
            end
        end

        // Reset with items in flight, then rerun the constant stimulus
        do_reset();
        clear_last();
        for (int i = 0; i < 40; i++) in_data[i] = 32'h4000_0000;
        in_last[39] = 1'b1;
        run(20, 0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1 check("midrst_m_valid", 64'(m_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run(40, 0, 1'b1);
        check("rerun_count", 64'(out_d.size()), 64'd40);
        for (int i = 0; i < 40; i++) check($sformatf("rerun[%0d]", i), 64'(out_d[i]), 64'(exp_const(i)));

        // Full-scale {32767,-32768} at L=512, SHIFT=25:
        // |x|^2 = 2147418113, 512*|x|^2 >> 25 = 32767, |x|^2 >> 25 = 63.
        do_reset();
        sel = 1'b1;
        clear_last();
        for (int i = 0; i < NMAX; i++) in_data[i] = 32'h7fff_8000;
        run(NMAX, 0, 1'b1);
        check("fs_count",    64'(out_d.size()), 64'(NMAX));
        check("fs_item0",    64'(out_d[0]),     64'h0000_003f);
        check("fs_item511",  64'(out_d[511]),   64'h0000_7fff);
        check("fs_item512",  64'(out_d[512]),   64'h003f_7fff);
        check("fs_item1023", 64'(out_d[1023]),  64'h7fff_7fff);
        check("fs_item1099", 64'(out_d[1099]),  64'h7fff_7fff);
        sel = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
